alarm_key_entry: RTL and testbench
==================================

# alarm_key_entry

Keypad entry stage that sits directly upstream of the alarm register. It collects a four-digit HH:MM alarm time from single-cycle key strobes into a shift buffer and range-checks the result. When the entry is confirmed, it presents the digits on new_alarm_time_* together with a one-cycle load_new_a pulse for the alarm register to capture. Stale entries are aborted by a seconds-based timeout.

## Interface
- TIMEOUT_SEC, 10: one_sec pulses without a key in ENTRY before the entry is aborted; legal range 1–255.
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; clears all state
- key_valid  input  1  one-cycle strobe; key_code is valid in that cycle
- key_code  input  4  0–9 digit, 10 ALARM (start/confirm), 11 CLEAR, 12–15 ignored
- one_sec  input  1  one-cycle pulse once per second
- new_alarm_time_ms_hr  output  4  tens-of-hours digit of buffer
- new_alarm_time_ls_hr  output  4  units-of-hours digit
- new_alarm_time_ms_min  output  4  tens-of-minutes digit
- new_alarm_time_ls_min  output  4  units-of-minutes digit
- load_new_a  output  1  one-cycle load strobe to alarm register
- entry_active  output  1  high while in ENTRY
- digit_count  output  3  digits entered in current entry, saturates at 4
- entry_error  output  1  one-cycle pulse on rejected confirm or timeout

## Operation
- FSM states: IDLE, ENTRY, LOAD, ERROR.
- IDLE:
  - ALARM key -> ENTRY; buffer cleared to 0, digit_count 0, timer 0.
  - All other keys ignored.
- ENTRY, digit key: shift buffer.
  - Shift: ms_hr<=ls_hr, ls_hr<=ms_min, ms_min<=ls_min, ls_min<=key.
  - digit_count increments, saturating at 4. A fifth or later digit drops the oldest digit.
  - Timer cleared.
- ENTRY, CLEAR key: buffer and digit_count to 0; stay in ENTRY; timer cleared.
- ENTRY, ALARM key:
  - digit_count==0 -> IDLE silently, no load.
  - Otherwise run the validity check. Pass -> LOAD; fail -> ERROR.
  - Partial entry is legal: missing leading digits read as 0, so "7","ALARM" gives 00:07.
- Validity check: ms_hr<=2; ls_hr<=9; if ms_hr==2 then ls_hr<=3; ms_min<=5; ls_min<=9.
- ENTRY timeout: one_sec with timer==TIMEOUT_SEC-1 -> ERROR.
- LOAD: load_new_a=1 for one cycle -> IDLE.
- ERROR: entry_error=1 for one cycle -> IDLE. Buffer is not altered.
- Codes 12–15 are ignored in every state.
- Keys arriving in LOAD or ERROR are dropped.
- Buffer holds its last value in IDLE. Outputs are driven directly from buffer registers.

## Timing
- Reset values: all new_alarm_time_* 0, load_new_a 0, entry_active 0, digit_count 0, entry_error 0, state IDLE, timer 0.
- Outputs are registered; load_new_a, entry_error and entry_active are Moore decodes of state.
- Confirm ALARM sampled at edge N -> load_new_a high in cycle N+1 only. The buffer is stable in cycle N+1 and the downstream register captures at the end of N+1. State is IDLE from N+2.
- A digit sampled at edge N is visible on outputs from cycle N+1.
- key_valid and one_sec in the same cycle: the key takes effect and the timer clears; no timeout that cycle.
- Back-to-back key strobes every cycle are supported in ENTRY.
- Reset mid-entry or during LOAD: next cycle is IDLE with buffer 0 and no load pulse.
- Timer width is 8 bits; it counts only in ENTRY and never wraps because the abort fires first.

## Configuration
- ALARM_ENTRY_VALIDATE_EN defined: the validity check above applies, and a failed confirm produces an entry_error pulse.
- Not defined: any confirm with digit_count>=1 goes to LOAD. entry_error pulses only on timeout.

## Structure
- Shared package alarm_pkg holds:
  - key code constants KEY_ALARM=10, KEY_CLEAR=11;
  - the FSM state enum (2-bit);
  - the BCD digit typedef (4-bit).
- Sub-module entry_timer: 8-bit one_sec counter with clear and enable inputs and an expired output compared against TIMEOUT_SEC.

## Test plan
- Reset, then ALARM,1,2,3,4,ALARM -> outputs 1,2,3,4 (ms_hr..ls_min); load_new_a high exactly one cycle, the cycle after the confirm strobe.
- ALARM,2,4,0,0,ALARM with VALIDATE_EN -> no load_new_a, entry_error one cycle, state IDLE. Without the macro -> load with 24:00.
- ALARM,9,1,2,3,5,ALARM -> buffer 1,2,3,5, digit_count 4, load pulse. ALARM,ALARM -> no load, no error.
- ALARM,1, then TIMEOUT_SEC=10 one_sec pulses -> entry_error on the 10th. One key strobe coinciding with the 10th pulse -> no abort.
- ALARM,1,CLEAR,0,7,ALARM -> buffer 0,0,0,7; load pulse. Digit keys while IDLE -> buffer unchanged.
- ALARM,1,2 then reset -> all outputs 0 next cycle; a later ALARM,ALARM gives no load.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm keypad entry stage: key codes,
// FSM states, BCD digit type and the HH:MM range check.
package alarm_pkg;

  localparam logic [3:0] KEY_ALARM = 4'd10;
  localparam logic [3:0] KEY_CLEAR = 4'd11;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    LOAD  = 2'd2,
    ERROR = 2'd3
  } state_t;

  // Digit order matches the shift direction: ms_hr is the oldest digit.
  typedef struct packed {
    bcd_t ms_hr;
    bcd_t ls_hr;
    bcd_t ms_min;
    bcd_t ls_min;
  } hhmm_t;

  function automatic logic time_valid(input hhmm_t t);
    return (t.ms_hr <= 4'd2) && (t.ls_hr <= 4'd9) &&
           !((t.ms_hr == 4'd2) && (t.ls_hr > 4'd3)) &&
           (t.ms_min <= 4'd5) && (t.ls_min <= 4'd9);
  endfunction

endpackage

// File: rtl/alarm_key_entry_if.sv
// Keypad strobe in, alarm-time digits and status out. The keypad side is
// the master; the entry stage is the slave.
interface alarm_key_entry_if;
  import alarm_pkg::*;

  logic       key_valid;
  logic [3:0] key_code;
  bcd_t       new_alarm_time_ms_hr;
  bcd_t       new_alarm_time_ls_hr;
  bcd_t       new_alarm_time_ms_min;
  bcd_t       new_alarm_time_ls_min;
  logic       load_new_a;
  logic       entry_active;
  logic [2:0] digit_count;
  logic       entry_error;

  modport master (
    output key_valid, key_code,
    input  new_alarm_time_ms_hr, new_alarm_time_ls_hr,
           new_alarm_time_ms_min, new_alarm_time_ls_min,
           load_new_a, entry_active, digit_count, entry_error
  );

  modport slave (
    input  key_valid, key_code,
    output new_alarm_time_ms_hr, new_alarm_time_ls_hr,
           new_alarm_time_ms_min, new_alarm_time_ls_min,
           load_new_a, entry_active, digit_count, entry_error
  );

endinterface

// File: rtl/entry_timer.sv
// Counts one_sec pulses while enabled; expired flags the last second before
// the entry must be aborted.
module entry_timer #(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset)       count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 8'd1;
  end

  assign expired = (count == 8'(TIMEOUT_SEC - 1));

endmodule

// File: rtl/alarm_key_entry.sv
// Keypad entry FSM: shifts in HH:MM digits, confirms or aborts, and pulses
// load_new_a for the alarm register. Define ALARM_ENTRY_VALIDATE_EN to
// reject out-of-range times on confirm.
module alarm_key_entry
  import alarm_pkg::*;
#(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              one_sec,
  alarm_key_entry_if.slave  kif
);

  state_t     state;
  hhmm_t      entry_buf;
  logic [2:0] count_q;
  logic       load_q;
  logic       error_q;
  logic       active_q;

  logic is_digit, is_alarm, is_clear, key_taken;
  logic timer_clear, timer_en, expired, timeout, confirm_ok;

  assign is_digit  = kif.key_valid && (kif.key_code <= 4'd9);
  assign is_alarm  = kif.key_valid && (kif.key_code == KEY_ALARM);
  assign is_clear  = kif.key_valid && (kif.key_code == KEY_CLEAR);
  assign key_taken = is_digit || is_alarm || is_clear;

  // Any accepted key restarts the inactivity window, even on a one_sec cycle.
  assign timer_clear = (state != ENTRY) || key_taken;
  assign timer_en    = (state == ENTRY) && one_sec;
  assign timeout     = timer_en && expired && !key_taken;

`ifdef ALARM_ENTRY_VALIDATE_EN
  assign confirm_ok = time_valid(entry_buf);
`else
  assign confirm_ok = 1'b1;
`endif

  entry_timer #(.TIMEOUT_SEC(TIMEOUT_SEC)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      entry_buf <= '0;
      count_q   <= '0;
      load_q    <= 1'b0;
      error_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      load_q  <= 1'b0;
      error_q <= 1'b0;
      case (state)
        IDLE: begin
          if (is_alarm) begin
            state     <= ENTRY;
            entry_buf <= '0;
            count_q   <= '0;
            active_q  <= 1'b1;
          end
        end
        ENTRY: begin
          if (is_digit) begin
            entry_buf <= {entry_buf.ls_hr, entry_buf.ms_min, entry_buf.ls_min, kif.key_code};
            count_q   <= (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;
          end else if (is_clear) begin
            entry_buf <= '0;
            count_q   <= '0;
          end else if (is_alarm) begin
            active_q <= 1'b0;
            if (count_q == 3'd0) begin
              state <= IDLE;
            end else if (confirm_ok) begin
              state  <= LOAD;
              load_q <= 1'b1;
            end else begin
              state   <= ERROR;
              error_q <= 1'b1;
            end
          end else if (timeout) begin
            state    <= ERROR;
            error_q  <= 1'b1;
            active_q <= 1'b0;
          end
        end
        LOAD:    state <= IDLE;
        ERROR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign kif.new_alarm_time_ms_hr  = entry_buf.ms_hr;
  assign kif.new_alarm_time_ls_hr  = entry_buf.ls_hr;
  assign kif.new_alarm_time_ms_min = entry_buf.ms_min;
  assign kif.new_alarm_time_ls_min = entry_buf.ls_min;
  assign kif.load_new_a            = load_q;
  assign kif.entry_error           = error_q;
  assign kif.entry_active          = active_q;
  assign kif.digit_count           = count_q;

endmodule

// File: tb/tb_alarm_key_entry.sv
// Directed bench for alarm_key_entry: confirm outcomes go through a
// scoreboard queue and are compared in the cycle the DUT responds.
module tb_alarm_key_entry;
  import alarm_pkg::*;

  localparam int unsigned TIMEOUT_SEC = 10;

`ifdef ALARM_ENTRY_VALIDATE_EN
  localparam logic VAL = 1'b1;
`else
  localparam logic VAL = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic one_sec;

  alarm_key_entry_if kif ();

  alarm_key_entry #(.TIMEOUT_SEC(TIMEOUT_SEC)) dut (
    .clk     (clk),
    .reset   (reset),
    .one_sec (one_sec),
    .kif     (kif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic  load;
    logic  err;
    hhmm_t t;
  } outcome_t;

  outcome_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] digits();
    return {kif.new_alarm_time_ms_hr, kif.new_alarm_time_ls_hr,
            kif.new_alarm_time_ms_min, kif.new_alarm_time_ls_min};
  endfunction

  // Key is held for one full clock period, sampled at the enclosed rising edge.
  task automatic send_key(input logic [3:0] c, input logic with_sec = 1'b0);
    kif.key_valid = 1'b1;
    kif.key_code  = c;
    one_sec       = with_sec;
    @(negedge clk);
    kif.key_valid = 1'b0;
    kif.key_code  = 4'd0;
    one_sec       = 1'b0;
  endtask

  task automatic sec_pulse();
    one_sec = 1'b1;
    @(negedge clk);
    one_sec = 1'b0;
  endtask

  task automatic expect_outcome(input logic load, input logic err, input logic [15:0] t);
    outcome_t o;
    o.load = load;
    o.err  = err;
    o.t    = hhmm_t'(t);
    sb.push_back(o);
  endtask

  // Called in the cycle after the confirming event; pulses must last one cycle.
  task automatic observe(input string tag);
    outcome_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_load"},   32'(kif.load_new_a),  32'(e.load));
    check({tag, "_err"},    32'(kif.entry_error), 32'(e.err));
    check({tag, "_digits"}, 32'(digits()),        32'(e.t));
    @(negedge clk);
    check({tag, "_load_1cyc"}, 32'(kif.load_new_a),   32'd0);
    check({tag, "_err_1cyc"},  32'(kif.entry_error),  32'd0);
    check({tag, "_idle"},      32'(kif.entry_active), 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    one_sec       = 1'b0;
    kif.key_valid = 1'b0;
    kif.key_code  = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_digits", 32'(digits()),           32'h0);
    check("rst_load",   32'(kif.load_new_a),     32'd0);
    check("rst_active", 32'(kif.entry_active),   32'd0);
    check("rst_count",  32'(kif.digit_count),    32'd0);
    check("rst_err",    32'(kif.entry_error),    32'd0);

    // Basic entry 12:34
    send_key(KEY_ALARM);
    check("t1_active", 32'(kif.entry_active), 32'd1);
    check("t1_count0", 32'(kif.digit_count),  32'd0);
    send_key(4'd1); send_key(4'd2); send_key(4'd3); send_key(4'd4);
    check("t1_buf",   32'(digits()),          32'h1234);
    check("t1_count", 32'(kif.digit_count),   32'd4);
    expect_outcome(1'b1, 1'b0, 16'h1234);
    send_key(KEY_ALARM);
    observe("t1");

    // 24:00 is out of range when validation is on
    send_key(KEY_ALARM);
    send_key(4'd2); send_key(4'd4); send_key(4'd0); send_key(4'd0);
    expect_outcome(!VAL, VAL, 16'h2400);
    send_key(KEY_ALARM);
    observe("t2_2400");

    // 23:59 is the upper legal boundary
    send_key(KEY_ALARM);
    send_key(4'd2); send_key(4'd3); send_key(4'd5); send_key(4'd9);
    expect_outcome(1'b1, 1'b0, 16'h2359);
    send_key(KEY_ALARM);
    observe("t2_2359");

    // 19:60 has illegal tens-of-minutes
    send_key(KEY_ALARM);
    send_key(4'd1); send_key(4'd9); send_key(4'd6); send_key(4'd0);
    expect_outcome(!VAL, VAL, 16'h1960);
    send_key(KEY_ALARM);
    observe("t2_1960");

    // Fifth digit drops the oldest
    send_key(KEY_ALARM);
    send_key(4'd9); send_key(4'd1); send_key(4'd2); send_key(4'd3); send_key(4'd5);
    check("t3_count", 32'(kif.digit_count), 32'd4);
    check("t3_buf",   32'(digits()),        32'h1235);
    expect_outcome(1'b1, 1'b0, 16'h1235);
    send_key(KEY_ALARM);
    observe("t3");

    // Empty confirm returns silently
    send_key(KEY_ALARM);
    check("t3_cleared", 32'(digits()), 32'h0);
    expect_outcome(1'b0, 1'b0, 16'h0000);
    send_key(KEY_ALARM);
    observe("t3_empty");

    // Timeout on the TIMEOUT_SEC-th pulse
    send_key(KEY_ALARM);
    send_key(4'd1);
    repeat (TIMEOUT_SEC - 1) sec_pulse();
    check("t4_pre_err",    32'(kif.entry_error),  32'd0);
    check("t4_pre_active", 32'(kif.entry_active), 32'd1);
    expect_outcome(1'b0, 1'b1, 16'h0001);
    sec_pulse();
    observe("t4_timeout");

    // Key coinciding with the final pulse wins
    send_key(KEY_ALARM);
    send_key(4'd1);
    repeat (TIMEOUT_SEC - 1) sec_pulse();
    send_key(4'd5, 1'b1);
    check("t4_co_err",    32'(kif.entry_error),  32'd0);
    check("t4_co_active", 32'(kif.entry_active), 32'd1);
    check("t4_co_buf",    32'(digits()),         32'h0015);
    sec_pulse();
    check("t4_restart", 32'(kif.entry_active), 32'd1);
    expect_outcome(1'b1, 1'b0, 16'h0015);
    send_key(KEY_ALARM);
    observe("t4_load");

    // CLEAR then partial entry
    send_key(KEY_ALARM);
    send_key(4'd1);
    send_key(KEY_CLEAR);
    check("t5_clr_count", 32'(kif.digit_count),  32'd0);
    check("t5_clr_buf",   32'(digits()),         32'h0);
    check("t5_clr_stay",  32'(kif.entry_active), 32'd1);
    send_key(4'd0); send_key(4'd7);
    expect_outcome(1'b1, 1'b0, 16'h0007);
    send_key(KEY_ALARM);
    observe("t5");
    send_key(4'd3); send_key(4'd4); send_key(4'd12);
    check("t5_idle_buf",    32'(digits()),         32'h0007);
    check("t5_idle_active", 32'(kif.entry_active), 32'd0);

    // Reset mid-entry
    send_key(KEY_ALARM);
    send_key(4'd1); send_key(4'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_buf",    32'(digits()),         32'h0);
    check("t6_count",  32'(kif.digit_count),  32'd0);
    check("t6_active", 32'(kif.entry_active), 32'd0);
    check("t6_load",   32'(kif.load_new_a),   32'd0);
    send_key(KEY_ALARM);
    expect_outcome(1'b0, 1'b0, 16'h0000);
    send_key(KEY_ALARM);
    observe("t6_empty");

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
